// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point divider:
// word layout, exponent bias, saturation value and FSM encoding.
package fp_pkg;

    localparam int NUMBER_LENGTH   = 27;
    localparam int EXPONENT_LENGTH = 8;
    localparam int FRACTION_LENGTH = 18;
    localparam int MANT_LENGTH     = FRACTION_LENGTH + 1;  // hidden 1 + fraction
    localparam int QUOT_LENGTH     = FRACTION_LENGTH + 2;  // one guard bit above the hidden 1

    localparam int EXP_BIAS = 127;

    localparam logic [EXPONENT_LENGTH-1:0] EXP_MAX  = 8'hFF;
    localparam logic [FRACTION_LENGTH-1:0] FRAC_MAX = 18'h3FFFF;

    // Magnitude used for both divide-by-zero and overflow results (sign added separately).
    localparam logic [NUMBER_LENGTH-2:0] SAT_MAG = {EXP_MAX, FRAC_MAX};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } fsm_state_t;

    // Control state of the divider, kept in one struct so checkers can bind to it.
    typedef struct packed {
        fsm_state_t state;
        logic       sign;
    } fp_ctrl_t;

endpackage

// File: rtl/fp_div_core.sv
// Restoring mantissa divider: one quotient bit per cycle, MSB first.
// quotient = floor(a_m * 2^(mant_length) / b_m), valid for a_m, b_m in [2^(m-1), 2^m).
// done is high in the cycle whose clock edge produces the final quotient bit.
module fp_div_core
    import fp_pkg::*;
#(
    parameter int mant_length = MANT_LENGTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [mant_length-1:0] a_m,
    input  logic [mant_length-1:0] b_m,
    output logic [mant_length:0] quotient,
    output logic                 done
);

    localparam int quot_length = mant_length + 1;
    localparam int cnt_width   = $clog2(quot_length);
    localparam logic [cnt_width-1:0] last_step = cnt_width'(quot_length - 1);

    // Partial remainder stays below 2*b_m, so mant_length+1 bits are enough.
    logic [mant_length:0]   rem_q;
    logic [mant_length-1:0] div_q;
    logic [cnt_width-1:0]   cnt_q;
    logic                   busy_q;
    logic                   ge;
    logic [mant_length:0]   rem_sub;

    // Trial subtraction: keep the difference only when it does not go negative.
    always_comb begin
        ge      = rem_q >= {1'b0, div_q};
        rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    end

    assign done = busy_q && (cnt_q == last_step);

    // Load operands on start, then shift in one quotient bit per cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q    <= '0;
            div_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem_q    <= {1'b0, a_m};
            div_q    <= b_m;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            quotient <= '0;
        end else if (busy_q) begin
            quotient <= {quotient[mant_length-1:0], ge};
            rem_q    <= {rem_sub[mant_length-1:0], 1'b0};
            cnt_q    <= cnt_q + cnt_width'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fp_divider.sv
// Floating-point divider: {sign, exp(bias 127), frac(hidden 1)}, truncating.
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high; a producer holds valid and data stable until that edge, and ready never
// depends combinationally on valid. in_ready is high only in IDLE, out_valid only
// in DONE, so the result handshake and a new accept can never share an edge.
// Latency: zero/divide-by-zero results are valid in the cycle after accept;
// normal results are valid in the 22nd cycle after accept (20 DIVIDE, 1 NORM, DONE).
module fp_divider
    import fp_pkg::*;
#(
    parameter int number_length   = NUMBER_LENGTH,
    parameter int exponent_length = EXPONENT_LENGTH,
    parameter int fraction_length = FRACTION_LENGTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [number_length-1:0] in_A,
    input  logic [number_length-1:0] in_B,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [number_length-1:0] out_Quot,
    output logic                     div_by_zero
);

    localparam int mant_length = fraction_length + 1;
    localparam int quot_length = fraction_length + 2;
    localparam int exp_calc_w  = exponent_length + 2;

    localparam logic signed [exp_calc_w-1:0] bias_s    = exp_calc_w'(EXP_BIAS);
    localparam logic signed [exp_calc_w-1:0] one_s     = exp_calc_w'(1);
    localparam logic signed [exp_calc_w-1:0] max_exp_s = exp_calc_w'((1 << exponent_length) - 1);

    // Operand fields
    logic                       a_s, b_s;
    logic [exponent_length-1:0] a_e, b_e;
    logic [fraction_length-1:0] a_f, b_f;

    assign a_s = in_A[number_length-1];
    assign b_s = in_B[number_length-1];
    assign a_e = in_A[number_length-2 -: exponent_length];
    assign b_e = in_B[number_length-2 -: exponent_length];
    assign a_f = in_A[fraction_length-1:0];
    assign b_f = in_B[fraction_length-1:0];

    fp_ctrl_t                   ctrl_q, ctrl_d;
    logic [exponent_length-1:0] a_e_q, b_e_q;
    logic [number_length-1:0]   quot_q, quot_d;
    logic                       dz_q, dz_d;
    logic                       capture;
    logic                       core_start;
    logic [quot_length-1:0]     core_quot;
    logic                       core_done;

    logic signed [exp_calc_w-1:0] exp_raw, exp_norm;
    logic [fraction_length-1:0]   norm_frac;
    logic [number_length-1:0]     norm_result;

    fp_div_core #(
        .mant_length(mant_length)
    ) u_core (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (core_start),
        .a_m     ({1'b1, a_f}),
        .b_m     ({1'b1, b_f}),
        .quotient(core_quot),
        .done    (core_done)
    );

    // Normalize the raw quotient and apply underflow/overflow limits.
    always_comb begin
        exp_raw = $signed({2'b00, a_e_q}) - $signed({2'b00, b_e_q}) + bias_s;
        if (core_quot[quot_length-1]) begin
            norm_frac = core_quot[fraction_length:1];
            exp_norm  = exp_raw;
        end else begin
            norm_frac = core_quot[fraction_length-1:0];
            exp_norm  = exp_raw - one_s;
        end
        if (exp_norm < one_s) begin
            norm_result = '0;
        end else if (exp_norm > max_exp_s) begin
            norm_result = {ctrl_q.sign, SAT_MAG};
        end else begin
            norm_result = {ctrl_q.sign, exp_norm[exponent_length-1:0], norm_frac};
        end
    end

    // Next-state and result selection; special operands bypass the divider.
    always_comb begin
        ctrl_d     = ctrl_q;
        quot_d     = quot_q;
        dz_d       = dz_q;
        capture    = 1'b0;
        core_start = 1'b0;
        case (ctrl_q.state)
            IDLE: begin
                if (in_valid) begin
                    if (b_e == '0) begin
                        ctrl_d.state = DONE;
                        quot_d       = {a_s ^ b_s, SAT_MAG};
                        dz_d         = 1'b1;
                    end else if (a_e == '0) begin
                        ctrl_d.state = DONE;
                        quot_d       = '0;
                        dz_d         = 1'b0;
                    end else begin
                        ctrl_d.state = DIVIDE;
                        ctrl_d.sign  = a_s ^ b_s;
                        dz_d         = 1'b0;
                        capture      = 1'b1;
                        core_start   = 1'b1;
                    end
                end
            end
            DIVIDE: begin
                if (core_done) begin
                    ctrl_d.state = NORM;
                end
            end
            NORM: begin
                ctrl_d.state = DONE;
                quot_d       = norm_result;
                dz_d         = 1'b0;
            end
            DONE: begin
                if (out_ready) begin
                    ctrl_d.state = IDLE;
                end
            end
            default: ctrl_d.state = IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q <= '{state: IDLE, sign: 1'b0};
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Captured exponents and the registered result held through DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_e_q  <= '0;
            b_e_q  <= '0;
            quot_q <= '0;
            dz_q   <= 1'b0;
        end else begin
            if (capture) begin
                a_e_q <= a_e;
                b_e_q <= b_e;
            end
            quot_q <= quot_d;
            dz_q   <= dz_d;
        end
    end

    assign in_ready    = reset_n && (ctrl_q.state == IDLE);
    assign out_valid   = (ctrl_q.state == DONE);
    assign out_Quot    = quot_q;
    assign div_by_zero = dz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed cases pinned to literals,
// random operands against a value-level reference model, backpressure and reset.
module tb_fp_divider;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] in_A;
    logic [26:0] in_B;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] out_Quot;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit seen = 0;

    logic [26:0] exp_q[$];
    logic        exp_dz_q[$];
    int          exp_at_q[$];

    fp_divider dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_A       (in_A),
        .in_B       (in_B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_Quot   (out_Quot),
        .div_by_zero(div_by_zero)
    );

    // Clock and cycle counter
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference model: {div_by_zero, quotient} from operand values.
    function automatic logic [27:0] model(input logic [26:0] a, input logic [26:0] b);
        logic   s;
        int     ae, be, e;
        longint am, bm, frac;
        s  = a[26] ^ b[26];
        ae = int'(a[25:18]);
        be = int'(b[25:18]);
        if (be == 0) return {1'b1, s, 26'h3FFFFFF};
        if (ae == 0) return 28'h0;
        am = longint'({1'b1, a[17:0]});
        bm = longint'({1'b1, b[17:0]});
        e  = ae - be + 127;
        if (am >= bm) begin
            // ratio in [1,2): keep 18 bits below the leading 1
            frac = (am * (longint'(1) << 18)) / bm - (longint'(1) << 18);
        end else begin
            // ratio in (0.5,1): one extra bit of scaling, exponent drops by one
            frac = (am * (longint'(1) << 19)) / bm - (longint'(1) << 18);
            e    = e - 1;
        end
        if (e < 1) return 28'h0;
        if (e > 255) return {1'b0, s, 26'h3FFFFFF};
        return {1'b0, s, e[7:0], frac[17:0]};
    endfunction

    function automatic int latency(input logic [26:0] a, input logic [26:0] b);
        return (a[25:18] == 8'h0 || b[25:18] == 8'h0) ? 1 : 22;
    endfunction

    // Compare process: checks outputs every cycle they are meaningful.
    always @(negedge clock) begin
        if (!reset_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 0);
            check("rst_out_quot", out_Quot, 0);
            check("rst_div_by_zero", div_by_zero, 0);
            seen = 0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", out_valid, 0);
            end else begin
                if (!seen) begin
                    check("latency", cyc, exp_at_q[0]);
                    seen = 1;
                end
                check("out_quot", out_Quot, exp_q[0]);
                check("div_by_zero", div_by_zero, exp_dz_q[0]);
                check("in_ready_while_done", in_ready, 0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(exp_dz_q.pop_front());
                    void'(exp_at_q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Present operands until accepted; record the expected result and its cycle.
    task automatic accept(input logic [26:0] a, input logic [26:0] b,
                          input logic [26:0] eq, input logic edz);
        bit ok = 0;
        in_A     = a;
        in_B     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                exp_q.push_back(eq);
                exp_dz_q.push_back(edz);
                exp_at_q.push_back(cyc + latency(a, b));
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_A     = 27'($urandom);
        in_B     = 27'($urandom);
    endtask

    // Wait for the pending result; out_ready low for 'hold' cycles, then random.
    // Junk on the input side must be ignored while the block is busy.
    task automatic drain(input int hold);
        bit ok = 0;
        out_ready = (hold > 0) ? 1'b0 : 1'b1;
        for (int c = 1; c < 400; c++) begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                in_valid = 1'b0;
                ok = 1;
                break;
            end
            out_ready = (c < hold) ? 1'b0 : ($urandom_range(0, 3) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_A      = 27'($urandom);
            in_B      = 27'($urandom);
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    logic [26:0] d_a  [9] = '{27'h2060000, 27'h1FC0000, 27'h6060000, 27'h1FC0000, 27'h0040000,
                              27'h3F80000, 27'h0000000, 27'h5FC0000, 27'h0000000};
    logic [26:0] d_b  [9] = '{27'h2000000, 27'h2020000, 27'h2000000, 27'h0000000, 27'h3F80000,
                              27'h0040000, 27'h2000000, 27'h0000000, 27'h0000000};
    logic [26:0] d_q  [9] = '{27'h2020000, 27'h1F55555, 27'h6020000, 27'h3FFFFFF, 27'h0000000,
                              27'h3FFFFFF, 27'h0000000, 27'h7FFFFFF, 27'h3FFFFFF};
    logic        d_dz [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    // Main stimulus
    initial begin
        logic [26:0] a, b;
        logic [27:0] m;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_A      = '0;
        in_B      = '0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clock);
        #1;

        // Directed cases: pin the model to literals, then run the DUT on them.
        for (int i = 0; i < 9; i++) begin
            check("model_pin", model(d_a[i], d_b[i]), {d_dz[i], d_q[i]});
            accept(d_a[i], d_b[i], d_q[i], d_dz[i]);
            drain($urandom_range(0, 2));
        end

        // Backpressure: result held for 10 DONE cycles with out_ready low.
        accept(27'h2060000, 27'h2000000, 27'h2020000, 1'b0);
        drain(22 + 10);
        accept(27'h1FC0000, 27'h0000000, 27'h3FFFFFF, 1'b1);
        drain(1 + 10);

        // Reset in the 10th DIVIDE cycle: the operation is abandoned.
        accept(27'h2060000, 27'h2000000, 27'h2020000, 1'b0);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        exp_dz_q.delete();
        exp_at_q.delete();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(negedge clock);
        check("in_ready_after_release", in_ready, 1);
        in_valid = 1'b0;
        repeat (30) @(posedge clock);
        #1;
        accept(27'h2060000, 27'h2000000, 27'h2020000, 1'b0);
        drain(0);

        // Random operands, occasional zero exponents and extreme exponents.
        for (int i = 0; i < 80; i++) begin
            a[26]    = 1'($urandom_range(0, 1));
            b[26]    = 1'($urandom_range(0, 1));
            a[25:18] = ($urandom_range(0, 9) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
            b[25:18] = ($urandom_range(0, 9) == 0) ? 8'h0 : 8'($urandom_range(1, 255));
            if ($urandom_range(0, 3) == 0) b[25:18] = 8'($urandom_range(1, 3));
            a[17:0]  = 18'($urandom);
            b[17:0]  = 18'($urandom);
            m = model(a, b);
            accept(a, b, m[26:0], m[27]);
            drain($urandom_range(0, 25));
        end

        repeat (5) @(posedge clock);
        check("queue_empty_at_end", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #5000000;
        check("watchdog", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have parameter number_length, default 27, total FP word width (sign/exponent/fraction).
REQ-002 SHALL have parameter exponent_length, default 8, exponent field width, bias 127.
REQ-003 SHALL have parameter fraction_length, default 18, stored fraction width, hidden leading 1.
REQ-004 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  in_A/in_B valid.
REQ-007 SHALL have port in_ready  output  1  block accepts operands.
REQ-008 SHALL have port in_A  input  27  dividend, {sign[26], exp[25:18], frac[17:0]}.
REQ-009 SHALL have port in_B  input  27  divisor, same format.
REQ-010 SHALL have port out_valid  output  1  out_Quot valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_Quot  output  27  quotient in_A/in_B.
REQ-013 SHALL have port div_by_zero  output  1  flag, valid with out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, DIVIDE, NORM, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL capture operands on the cycle in_valid&&in_ready; no other input sampling.
REQ-016 SHALL treat an operand with exponent field 0 as zero; no infinity, NaN or denorms exist.
REQ-017 SHALL, if A_e==0 and B_e!=0, go IDLE->DONE with out_Quot=27'h0, div_by_zero=0; out_valid 1 cycle after accept.
REQ-018 SHALL, if B_e==0 (including A_e==0), go IDLE->DONE with out_Quot={A_s^B_s, 8'hFF, 18'h3FFFF}, div_by_zero=1.
REQ-019 SHALL, otherwise, form 19-bit mantissas {1,frac} and run restoring division, one quotient bit per cycle, 20 DIVIDE cycles, q=floor(A_m*2^19/B_m), truncation only.
REQ-020 SHALL, in NORM, compute exp = A_e - B_e + 127 in 10-bit signed; if q[19]=1, frac=q[18:1]; else frac=q[17:0], exp-=1.
REQ-021 SHALL output 27'h0 (sign cleared) when normalized exp < 1 (underflow).
REQ-022 SHALL output {sign, 8'hFF, 18'h3FFFF} when normalized exp > 255 (saturate), div_by_zero=0.
REQ-023 SHALL set sign = A_s ^ B_s for all non-zero results.
REQ-024 SHALL, for normal operands, assert out_valid exactly 22 cycles after accept edge (20 DIVIDE + 1 NORM + registration into DONE).
REQ-025 SHALL hold out_valid, out_Quot, div_by_zero stable in DONE until out_ready=1; DONE->IDLE on that edge.
REQ-026 SHALL not accept new operands in the cycle the result handshake completes; in_ready rises the following cycle.
REQ-027 SHALL ignore in_valid and in_A/in_B changes while not in IDLE.

Reset
REQ-028 SHALL, on reset_n=0 at any time (including mid-DIVIDE or DONE), immediately enter IDLE, abandon the in-flight operation, drive out_valid=0, out_Quot=27'h0, div_by_zero=0, in_ready=0 while reset_n=0.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset_n deasserts.

Structure
REQ-030 SHALL place width parameters, bias 127, exponent 8'hFF, saturate value and FSM state encoding in shared package fp_pkg.
REQ-031 SHALL isolate the restoring-division datapath in sub-module fp_div_core (start, 20-bit quotient, done); FSM, special cases and normalization stay in fp_divider.

Verification
REQ-032 SHALL verify 6.0/2.0: in_A=27'h2060000, in_B=27'h2000000 -> out_Quot=27'h2020000 (3.0) exactly 22 cycles after accept, div_by_zero=0.
REQ-033 SHALL verify 1.0/3.0: in_A=27'h1FC0000, in_B=27'h2020000 -> out_Quot=27'h1F55555 (truncated).
REQ-034 SHALL verify sign: in_A=27'h6060000 (-6.0), in_B=27'h2000000 -> out_Quot=27'h6020000 (-3.0).
REQ-035 SHALL verify divide-by-zero: in_A=27'h1FC0000, in_B=27'h0 -> out_Quot=27'h3FFFFFF, div_by_zero=1, out_valid 1 cycle after accept; and underflow: in_A exp 1, in_B exp 254 -> out_Quot=27'h0.
REQ-036 SHALL verify backpressure and reset: out_ready=0 for 10 cycles holds result and in_ready=0; reset_n pulsed low at DIVIDE cycle 10 -> out_valid never asserts, in_ready=1 the cycle after release, next division correct.
